mouse_transmitter: RTL and testbench



---
 rtl/mouse_tx_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 65 ++++++
 rtl/mouse_transmitter.sv | 197 +++++++++++++++++++
 tb/tb_mouse_transmitter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mouse_tx_pkg.sv
// Shared definitions for the PS/2 host-to-mouse transmitter: state codes,
// frame length, default timing parameters and the parity helper.
`timescale 1ns/1ps
package mouse_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_INHIBIT      = 3'd1;
    localparam state_t ST_REQUEST      = 3'd2;
    localparam state_t ST_SEND         = 3'd3;
    localparam state_t ST_WAIT_ACK     = 3'd4;
    localparam state_t ST_WAIT_RELEASE = 3'd5;

    // start + 8 data + parity + stop; the device ACK arrives on the next edge
    localparam int FRAME_BITS = 11;

    localparam int DEFAULT_INHIBIT_CYCLES = 5000;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;
    localparam int DEFAULT_FILTER_CYCLES  = 8;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a PS/2 line with an optional stability filter
// (FILTER_EN) and a one-cycle pulse on each synchronized falling edge.
`timescale 1ns/1ps
module ps2_line_sync #(
    parameter bit FILTER_EN     = 1'b0,
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic level_w;

    // Idle PS/2 lines are pulled high, so every stage resets to 1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    generate
        if (FILTER_EN) begin : g_filter
            localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
            logic [CW-1:0] cnt_q;
            logic          filt_q;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (sync_q == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                    filt_q <= sync_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign level_w = filt_q;
        end else begin : g_plain
            assign level_w = sync_q;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) prev_q <= 1'b1;
        else         prev_q <= level_w;
    end

    assign level_o = level_w;
    assign fall_o  = prev_q & ~level_w;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: sends one command byte with inhibit,
// request-to-send, LSB-first data, odd parity, stop and ACK check.
// Define MOUSE_TX_CLK_FILTER_EN to add a glitch filter on the mouse clock.
`timescale 1ns/1ps
module mouse_transmitter
    import mouse_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FILTER_CYCLES  = DEFAULT_FILTER_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    input  logic       DATA_MOUSE_IN,
    output logic       DATA_MOUSE_OUT,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BYTE_SENT
);

`ifdef MOUSE_TX_CLK_FILTER_EN
    localparam bit CLK_FILTER_EN = 1'b1;
`else
    localparam bit CLK_FILTER_EN = 1'b0;
`endif

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       STOP_CNT = 4'(FRAME_BITS - 2);

    logic clk_sync;
    logic clk_fall;
    logic data_meta_q;
    logic data_sync_q;

    ps2_line_sync #(
        .FILTER_EN     (CLK_FILTER_EN),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_clk_sync (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .line_i  (CLK_MOUSE_IN),
        .level_o (clk_sync),
        .fall_o  (clk_fall)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= DATA_MOUSE_IN;
            data_sync_q <= data_meta_q;
        end
    end

    state_t           state_q,   state_d;
    logic [8:0]       frame_q,   frame_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic             clk_en_q,  clk_en_d;
    logic             data_en_q, data_en_d;
    logic             data_out_q, data_out_d;
    logic             sent_q,    sent_d;
    logic             watched;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        clk_en_d   = clk_en_q;
        data_en_d  = data_en_q;
        data_out_d = data_out_q;
        sent_d     = sent_q;
        timeout_d  = (timeout_q == TO_MAX) ? timeout_q : timeout_q + 1'b1;
        if (clk_fall) timeout_d = '0;

        case (state_q)
            ST_IDLE: begin
                clk_en_d   = 1'b0;
                data_en_d  = 1'b0;
                data_out_d = 1'b1;
                if (SEND_BYTE) begin
                    sent_d = 1'b0;
                    if (clk_sync && data_sync_q) begin
                        frame_d   = {odd_parity(BYTE_TO_SEND), BYTE_TO_SEND};
                        inh_cnt_d = '0;
                        clk_en_d  = 1'b1;
                        state_d   = ST_INHIBIT;
                    end
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    clk_en_d   = 1'b0;
                    data_en_d  = 1'b1;
                    data_out_d = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = ST_REQUEST;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_REQUEST, ST_SEND: begin
                // Falling edge k presents frame bit k-1; edge 10 releases the stop bit.
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == STOP_CNT) begin
                        data_en_d  = 1'b0;
                        data_out_d = 1'b1;
                        state_d    = ST_WAIT_ACK;
                    end else begin
                        data_out_d = frame_q[0];
                        frame_d    = {1'b1, frame_q[8:1]};
                        state_d    = ST_SEND;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (!data_sync_q) begin
                        state_d = ST_WAIT_RELEASE;
                    end else begin
                        state_d = ST_IDLE;
                        sent_d  = 1'b0;
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (clk_sync && data_sync_q) begin
                    sent_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (watched && timeout_q == TO_MAX) begin
            state_d    = ST_IDLE;
            clk_en_d   = 1'b0;
            data_en_d  = 1'b0;
            data_out_d = 1'b1;
            sent_d     = 1'b0;
        end

        if (state_d != state_q) timeout_d = '0;
    end

    assign watched = (state_q == ST_REQUEST) || (state_q == ST_SEND) ||
                     (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_RELEASE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            timeout_q  <= '0;
            clk_en_q   <= 1'b0;
            data_en_q  <= 1'b0;
            data_out_q <= 1'b1;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            timeout_q  <= timeout_d;
            clk_en_q   <= clk_en_d;
            data_en_q  <= data_en_d;
            data_out_q <= data_out_d;
            sent_q     <= sent_d;
        end
    end

    // NOTE: the frame register is pure datapath, loaded before it is ever
    // shifted out, so it carries no reset.
    always_ff @(posedge CLK) begin
        frame_q <= frame_d;
    end

    assign CLK_MOUSE_OUT_EN  = clk_en_q;
    assign DATA_MOUSE_OUT_EN = data_en_q;
    assign DATA_MOUSE_OUT    = data_out_q;
    assign BYTE_SENT         = sent_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Self-checking bench for mouse_transmitter: a behavioural PS/2 mouse clocks
// frames out of the host and the received bits are compared with the byte.
`timescale 1ns/1ps
module tb_mouse_transmitter;

    localparam int INHIBIT = 4;
    localparam int TIMEOUT = 200;
    localparam int FILTER  = 8;
`ifdef MOUSE_TX_CLK_FILTER_EN
    localparam int HALF_NS  = 200;
    localparam bit GLITCHES = 1'b1;
`else
    localparam int HALF_NS  = 40;
    localparam bit GLITCHES = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       SEND_BYTE = 1'b0;
    logic [7:0] BYTE_TO_SEND = 8'h00;
    logic       CLK_MOUSE_OUT_EN;
    logic       DATA_MOUSE_OUT;
    logic       DATA_MOUSE_OUT_EN;
    logic       BYTE_SENT;

    logic mouse_clk_drv  = 1'b1;
    logic mouse_data_drv = 1'b1;
    logic clk_pin;
    logic data_pin;

    // Open-collector wired-AND of host and mouse drivers.
    assign clk_pin  = mouse_clk_drv & ~CLK_MOUSE_OUT_EN;
    assign data_pin = mouse_data_drv & (~DATA_MOUSE_OUT_EN | DATA_MOUSE_OUT);

    int   checks   = 0;
    int   failures = 0;
    logic smp [1:12];

    always #5 CLK = ~CLK;

    mouse_transmitter #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_CYCLES  (FILTER)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .CLK_MOUSE_IN      (clk_pin),
        .CLK_MOUSE_OUT_EN  (CLK_MOUSE_OUT_EN),
        .DATA_MOUSE_IN     (data_pin),
        .DATA_MOUSE_OUT    (DATA_MOUSE_OUT),
        .DATA_MOUSE_OUT_EN (DATA_MOUSE_OUT_EN),
        .SEND_BYTE         (SEND_BYTE),
        .BYTE_TO_SEND      (BYTE_TO_SEND),
        .BYTE_SENT         (BYTE_SENT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit the mouse should see on rising clock k: data LSB first, odd parity, stop.
    function automatic logic exp_frame_bit(input logic [7:0] b, input int k);
        if (k <= 8)  return b[k-1];
        if (k == 9)  return ($countones(b) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic send_request(input logic [7:0] b);
        @(negedge CLK);
        SEND_BYTE    = 1'b1;
        BYTE_TO_SEND = b;
        @(negedge CLK);
        SEND_BYTE    = 1'b0;
        BYTE_TO_SEND = 8'($urandom);
    endtask

    task automatic measure_inhibit(output int hi, output logic start_ok);
        hi       = 0;
        start_ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (CLK_MOUSE_OUT_EN) begin
                hi++;
            end else if (hi > 0) begin
                start_ok = DATA_MOUSE_OUT_EN && !DATA_MOUSE_OUT && !data_pin;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic mouse_clocks(input int n, input bit ack);
        for (int k = 1; k <= n; k++) begin
            if (ack && k == 11) mouse_data_drv = 1'b0;
            mouse_clk_drv = 1'b0;
            #(HALF_NS);
            smp[k]        = data_pin;
            mouse_clk_drv = 1'b1;
            if (ack && k == 11) mouse_data_drv = 1'b1;
            if (GLITCHES) begin
                #(HALF_NS / 2 + 5);
                mouse_clk_drv = 1'b0;
                #5;
                mouse_clk_drv = 1'b1;
                #(HALF_NS / 2 - 10);
            end else begin
                #(HALF_NS);
            end
        end
    endtask

    task automatic run_transfer(input logic [7:0] b, input int n, input bit ack, input bit poke);
        int   hi;
        logic start_ok;
        send_request(b);
        check($sformatf("sent_cleared_%02h", b), BYTE_SENT, 1'b0);
        measure_inhibit(hi, start_ok);
        check($sformatf("inhibit_len_%02h", b), hi, INHIBIT);
        check($sformatf("start_bit_%02h", b), start_ok, 1'b1);
        if (poke) begin
            SEND_BYTE    = 1'b1;
            BYTE_TO_SEND = ~b;
            @(negedge CLK);
            SEND_BYTE    = 1'b0;
        end
        repeat ($urandom_range(4, 0)) @(negedge CLK);
        #7;
        mouse_clocks(n, ack);
        for (int k = 1; k <= n && k <= 10; k++)
            check($sformatf("frame_%02h_bit%0d", b, k), smp[k], exp_frame_bit(b, k));
    endtask

    task automatic expect_idle(input string tag, input logic sent);
        check({tag, "_clk_en"},  CLK_MOUSE_OUT_EN,  1'b0);
        check({tag, "_data_en"}, DATA_MOUSE_OUT_EN, 1'b0);
        check({tag, "_sent"},    BYTE_SENT,         sent);
    endtask

    task automatic acked_transfer(input logic [7:0] b, input bit poke);
        run_transfer(b, 11, 1'b1, poke);
        repeat (FILTER + 12) @(negedge CLK);
        expect_idle($sformatf("done_%02h", b), 1'b1);
    endtask

    initial begin
        int hi;

        repeat (3) @(negedge CLK);
        check("reset_clk_en",   CLK_MOUSE_OUT_EN,  1'b0);
        check("reset_data_en",  DATA_MOUSE_OUT_EN, 1'b0);
        check("reset_data_out", DATA_MOUSE_OUT,    1'b1);
        check("reset_sent",     BYTE_SENT,         1'b0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        acked_transfer(8'hAA, 1'b0);

        // Mouse holds data low: the request is dropped, BYTE_SENT cleared.
        mouse_data_drv = 1'b0;
        repeat (4) @(negedge CLK);
        send_request(8'hCC);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (CLK_MOUSE_OUT_EN) hi++;
            @(negedge CLK);
        end
        check("busy_no_inhibit", hi, 0);
        check("busy_sent", BYTE_SENT, 1'b0);
        mouse_data_drv = 1'b1;
        repeat (4) @(negedge CLK);

        // Only five clocks: the timeout aborts the transfer.
        run_transfer(8'hF0, 5, 1'b0, 1'b0);
        repeat (100) @(negedge CLK);
        check("timeout_still_busy", DATA_MOUSE_OUT_EN, 1'b1);
        repeat (150) @(negedge CLK);
        expect_idle("timeout", 1'b0);
        check("timeout_data_out", DATA_MOUSE_OUT, 1'b1);

        // No ACK on edge 11 aborts; the twelfth edge is ignored.
        run_transfer(8'h55, 12, 1'b0, 1'b0);
        repeat (FILTER + 12) @(negedge CLK);
        expect_idle("noack", 1'b0);

        acked_transfer(8'h33, 1'b0);
        acked_transfer(8'h00, 1'b1);
        acked_transfer(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) acked_transfer(8'($urandom), 1'b0);

        // Reset in the middle of the data bits releases both lines.
        run_transfer(8'($urandom), 4, 1'b0, 1'b0);
        check("pre_reset_busy", DATA_MOUSE_OUT_EN, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        expect_idle("midreset", 1'b0);
        check("midreset_data_out", DATA_MOUSE_OUT, 1'b1);
        RESET = 1'b1;
        repeat (FILTER + 4) @(negedge CLK);

        acked_transfer(8'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
